// File: rtl/fp16_pkg.sv
// fp16_pkg: FP16 field constants, helpers and squarer state encoding.
// Shared by the squarer and the square-root unit.
package fp16_pkg;

  localparam int FP16_BIAS   = 15;
  localparam int FP16_EXP_W  = 5;
  localparam int FP16_FRAC_W = 10;

  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic [15:0] FP16_PINF = 16'h7C00;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    NORM,
    DONE
  } sq_state_t;

  function automatic logic [FP16_EXP_W-1:0] fp16_exp(
    input logic [15:0] v
  );
    return v[14:10];
  endfunction

  function automatic logic [FP16_FRAC_W-1:0] fp16_frac(
    input logic [15:0] v
  );
    return v[9:0];
  endfunction

  // significand with the hidden bit restored for normal numbers
  function automatic logic [FP16_FRAC_W:0] fp16_sig(
    input logic [15:0] v
  );
    return {v[14:10] != '0, v[9:0]};
  endfunction

endpackage

// File: rtl/fp16_square_if.sv
// fp16_square_if: valid/ready operand and result channels of the squarer.
// master drives operands and takes results, slave is the squarer.
interface fp16_square_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] y;
  logic        ovf;
  logic        unf;

  modport master (
    output in_valid, x, out_ready,
    input  in_ready, out_valid, y, ovf, unf
  );

  modport slave (
    input  in_valid, x, out_ready,
    output in_ready, out_valid, y, ovf, unf
  );
endinterface

// File: rtl/fp16_mant_mul_seq.sv
// fp16_mant_mul_seq: WxW sequential shift-add multiplier, one bit per cycle.
// done is high during the last add cycle; product is final the cycle after.
module fp16_mant_mul_seq #(
  parameter int W = 11
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [CW-1:0]  cnt;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mb;

  assign done = busy && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy    <= 1'b0;
      cnt     <= '0;
      mcand   <= '0;
      mb      <= '0;
      product <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      cnt     <= '0;
      mcand   <= {{W{1'b0}}, a};
      mb      <= b;
      product <= '0;
    end else if (busy) begin
      if (mb[0])
        product <= product + mcand;
      mcand <= mcand << 1;
      mb    <= mb >> 1;
      cnt   <= cnt + CW'(1);
      if (done)
        busy <= 1'b0;
    end
  end
endmodule

// File: rtl/fp16_square.sv
// fp16_square: iterative FP16 squarer y = x*x, result 12 cycles after accept.
// Define FP16_SQUARE_RNE_EN for round-to-nearest-even, else truncation.
module fp16_square
  import fp16_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MANT_W     = 11
) (
  input  logic         clk,
  input  logic         reset,
  fp16_square_if.slave io
);
`ifdef FP16_SQUARE_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  sq_state_t state, nxt;

  logic [DATA_WIDTH-2:0] xr;
  logic [2*MANT_W-1:0]   p;
  logic                  mbusy, mdone, start;
  logic [15:0]           y_q, y_n;
  logic                  ovf_q, ovf_n, unf_q, unf_n;

  logic [FP16_EXP_W-1:0]  ex;
  logic [FP16_FRAC_W-1:0] frac;
  logic                   g, s, up, c;
  logic signed [7:0]      be;
  logic                   nan, inf, zro, fin, of, uf, nrm;

  assign start        = io.in_valid && (state == IDLE);
  assign io.in_ready  = state == IDLE;
  assign io.out_valid = state == DONE;
  assign io.y         = y_q;
  assign io.ovf       = ovf_q;
  assign io.unf       = unf_q;

  fp16_mant_mul_seq #(.W(MANT_W)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (fp16_sig(io.x)),
    .b       (fp16_sig(io.x)),
    .busy    (mbusy),
    .done    (mdone),
    .product (p)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      xr    <= '0;
      y_q   <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      state <= nxt;
      if (start)
        xr <= io.x[DATA_WIDTH-2:0];
      if (state == NORM) begin
        y_q   <= y_n;
        ovf_q <= ovf_n;
        unf_q <= unf_n;
      end
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = MUL;
      MUL:     if (mbusy && mdone) nxt = NORM;
      NORM:    nxt = DONE;
      DONE:    if (io.out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    ex = fp16_exp({1'b0, xr});
    be = (($signed({3'b000, ex}) - 8'sd15) <<< 1) + 8'sd15;
    if (p[21]) begin
      be   = be + 8'sd1;
      frac = p[20:11];
      g    = p[10];
      s    = |p[9:0];
    end else begin
      frac = p[19:10];
      g    = p[9];
      s    = |p[8:0];
    end
    // mantissa carry-out of rounding bumps the exponent
    up        = RNE && g && (s || frac[0]);
    {c, frac} = {1'b0, frac} + {10'd0, up};
    if (c)
      be = be + 8'sd1;

    nan = (ex == '1) && (fp16_frac({1'b0, xr}) != '0);
    inf = (ex == '1) && !nan;
    zro = ex == '0;
    fin = !nan && !inf && !zro;
    of  = fin && (be > 8'sd30);
    uf  = fin && (be < 8'sd1);
    nrm = fin && !of && !uf;

    y_n   = '0;
    ovf_n = 1'b0;
    unf_n = 1'b0;
    unique case (1'b1)
      nan: y_n = FP16_QNAN;
      inf: y_n = FP16_PINF;
      zro: y_n = '0;
      of: begin
        y_n   = FP16_PINF;
        ovf_n = 1'b1;
      end
      uf:  unf_n = 1'b1;
      nrm: y_n = {1'b0, be[4:0], frac};
      default: ;
    endcase
  end
endmodule
